// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scan-code decoder: pops bytes from the receiver FIFO, folds E0/F0 prefixes
// into key events and tracks held keys. Optional macro: KBD_TYPEMATIC_FILTER_EN.
module ps2_kbd_ctrl #(
  parameter int unsigned RD_GAP = 0
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [7:0]  kb_data,
  input  logic        kb_ready,
  input  logic        kb_overflow,
  output logic        kb_nextdata_n,
  output logic        evt_valid,
  input  logic        evt_ack,
  output logic [7:0]  evt_code,
  output logic        evt_ext,
  output logic        evt_release,
  output logic        evt_repeat,
  output logic [3:0]  keys_down,
  output logic [15:0] press_cnt,
  output logic        ovf_seen
);

  // Consumer handshake: an event is offered while evt_valid=1 with all evt_* fields held
  // stable; it is taken on the clock edge where evt_ack=1, and evt_ack is ignored otherwise.
  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_DEC,
    S_EMIT
  } state_t;

  localparam logic [1:0] GAP = RD_GAP[1:0];

  state_t       state;
  logic [7:0]   byte_q;
  logic         ext_pend;
  logic         brk_pend;
  logic [1:0]   gap_cnt;
  logic [511:0] held;
  logic         rep_q;

  logic [8:0]   idx;
  logic         is_held;
  logic         is_drop;
  logic         is_repeat;
  logic         discard;

`ifdef KBD_TYPEMATIC_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
  assign evt_repeat = 1'b0;
`else
  localparam bit FILTER_EN = 1'b0;
  assign evt_repeat = rep_q;
`endif

  assign idx       = {ext_pend, byte_q};
  assign is_held   = held[idx];
  assign is_repeat = !brk_pend && is_held;
  assign discard   = is_repeat && FILTER_EN;

  always_comb begin
    is_drop = 1'b0;
    case (byte_q)
      8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: is_drop = 1'b1;
      default:                                  is_drop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state         <= S_IDLE;
      byte_q        <= 8'h00;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
      gap_cnt       <= 2'd0;
      held          <= '0;
      rep_q         <= 1'b0;
      kb_nextdata_n <= 1'b1;
      evt_valid     <= 1'b0;
      evt_code      <= 8'h00;
      evt_ext       <= 1'b0;
      evt_release   <= 1'b0;
      keys_down     <= 4'd0;
      press_cnt     <= 16'd0;
      ovf_seen      <= 1'b0;
    end else begin
      if (kb_overflow) ovf_seen <= 1'b1;

      case (state)
        S_IDLE: begin
          if (kb_ready) begin
            byte_q        <= kb_data;
            kb_nextdata_n <= 1'b0;
            state         <= S_POP;
          end
        end

        S_POP: begin
          kb_nextdata_n <= 1'b1;
          gap_cnt       <= 2'd0;
          state         <= S_DEC;
        end

        S_DEC: begin
          if (gap_cnt != GAP) begin
            gap_cnt <= gap_cnt + 2'd1;
          end else if (byte_q == 8'hE0) begin
            ext_pend <= 1'b1;
            state    <= S_IDLE;
          end else if (byte_q == 8'hF0) begin
            brk_pend <= 1'b1;
            state    <= S_IDLE;
          end else if (is_drop) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            state    <= S_IDLE;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            // Bitmap and counters only move on a real press or a release of a held key.
            if (brk_pend && is_held) begin
              held[idx] <= 1'b0;
              if (keys_down != 4'd0) keys_down <= keys_down - 4'd1;
            end else if (!brk_pend && !is_held) begin
              held[idx] <= 1'b1;
              press_cnt <= press_cnt + 16'd1;
              if (keys_down != 4'hF) keys_down <= keys_down + 4'd1;
            end
            if (discard) begin
              state <= S_IDLE;
            end else begin
              evt_code    <= byte_q;
              evt_ext     <= ext_pend;
              evt_release <= brk_pend;
              rep_q       <= is_repeat;
              evt_valid   <= 1'b1;
              state       <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          if (evt_ack) begin
            evt_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
